// File: rtl/kbd_fifo.sv
// Key-event FIFO: turns the decoder's level-style ASCII into press events with
// typematic auto-repeat, and queues them for the CPU to pop one at a time.
module kbd_fifo #(
    parameter int DEPTH         = 16,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 50000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             key_ascii,
    input  logic                   rd_en,
    input  logic                   clear,
    output logic [7:0]             dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW   = $clog2(CMAX) + 1;

    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] DELAY_END  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] PERIOD_END = CW'(REPEAT_PERIOD);
    localparam logic          REPEAT_EN  = (REPEAT_DELAY != 0);
    localparam logic [AW:0]   PTR_ONE    = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rep_state_t;

    // ------------------------------------------------------------------
    // Press detection and repeat timer
    // ------------------------------------------------------------------
    logic [7:0]    prev_key;
    logic          press;
    logic          key_held;
    rep_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          rep_push;

    assign key_held = (key_ascii != 8'h00);
    assign press    = key_held && (key_ascii != prev_key);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rep_push  = 1'b0;
        case (state)
            IDLE: begin
                if (press && REPEAT_EN) begin
                    state_nxt = DELAY;
                    cnt_nxt   = CNT_ONE;
                end
            end
            DELAY, REPEAT: begin
                if (!key_held) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (press) begin
                    // A different key restarts the full initial delay
                    state_nxt = DELAY;
                    cnt_nxt   = CNT_ONE;
                end else if (cnt == ((state == DELAY) ? DELAY_END : PERIOD_END)) begin
                    rep_push  = 1'b1;
                    state_nxt = REPEAT;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO storage and pointers (one extra wrap bit)
    // ------------------------------------------------------------------
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        push_req;
    logic        do_pop;
    logic        do_push;
    logic        drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    // Press and repeat requests never coincide, so a simple OR suffices
    assign push_req = press || rep_push;
    assign do_pop   = rd_en && !empty;
    assign do_push  = push_req && (!full || do_pop);
    assign drop     = push_req && full && !do_pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_key <= 8'h00;
            state    <= IDLE;
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            prev_key <= key_ascii;
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            if (clear) begin
                // Flush only the queue; a held key keeps repeating afterwards
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
                if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
                if (drop)    overflow <= 1'b1;
            end
        end
    end

    // When full with a pop, the write slot is the head being retired this edge
    always_ff @(posedge clock) begin
        if (do_push && !clear)
            mem[wr_ptr[AW-1:0]] <= key_ascii;
    end

endmodule

// File: tb/tb_kbd_fifo.sv
// Self-checking bench for kbd_fifo: directed scenarios plus random key/pop/clear
// traffic compared each cycle against a queue-and-age reference model.
module tb_kbd_fifo;

    localparam int DEPTH = 8;
    localparam int RD    = 4;
    localparam int RP    = 2;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic            clock;
    logic            reset;
    logic [7:0]      key_ascii;
    logic            rd_en;
    logic            clear;
    logic [7:0]      dout;
    logic            empty;
    logic            full;
    logic [CNTW-1:0] count;
    logic            overflow;

    int checks = 0;
    int errors = 0;

    kbd_fifo #(.DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clock(clock), .reset(reset), .key_ascii(key_ascii), .rd_en(rd_en),
        .clear(clear), .dout(dout), .empty(empty), .full(full),
        .count(count), .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: a queue of events, a sticky overflow bit, and the age of the current hold
    logic [7:0] q[$];
    bit         ovf_m;
    logic [7:0] prev_m;
    int         age;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ovf_m  = 1'b0;
        prev_m = 8'h00;
        age    = 0;
    endtask

    task automatic model_edge(input logic [7:0] k, input bit rd, input bit clr);
        bit push_req;
        bit pop;
        push_req = 1'b0;
        if (k != 0 && k != prev_m) begin
            push_req = 1'b1;
            age = 0;
        end else if (k != 0) begin
            age++;
            if (RD != 0 && age >= RD && ((age - RD) % RP) == 0) push_req = 1'b1;
        end
        pop = rd && (q.size() > 0);
        if (clr) begin
            q.delete();
            ovf_m = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push_req) begin
                if (q.size() < DEPTH) q.push_back(k);
                else ovf_m = 1'b1;
            end
        end
        prev_m = k;
    endtask

    task automatic check_outputs();
        chk("dout",     32'(dout),     (q.size() > 0) ? 32'(q[0]) : 32'h0);
        chk("empty",    32'(empty),    32'(q.size() == 0));
        chk("full",     32'(full),     32'(q.size() == DEPTH));
        chk("count",    32'(count),    32'(q.size()));
        chk("overflow", 32'(overflow), 32'(ovf_m));
    endtask

    task automatic step(input logic [7:0] k, input bit rd, input bit clr);
        key_ascii = k;
        rd_en     = rd;
        clear     = clr;
        @(posedge clock);
        model_edge(k, rd, clr);
        #1;
        check_outputs();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        logic [7:0] cur;
        int         hold;

        key_ascii = 8'h00;
        rd_en     = 1'b0;
        clear     = 1'b0;
        reset     = 1'b1;
        model_reset();
        #2;
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_dout",  32'(dout),  32'h0);
        chk("rst_full",  32'(full),  32'h0);
        chk("rst_ovf",   32'(overflow), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Single press, then pop
        step(8'h41, 1'b0, 1'b0);
        chk("press_dout",  32'(dout),  32'h41);
        chk("press_count", 32'(count), 32'h1);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        chk("pop_empty", 32'(empty), 32'h1);
        chk("pop_dout",  32'(dout),  32'h0);

        // Held key: pushes at press, +4, +6, +8, +10
        for (int i = 0; i < 12; i++) step(8'h61, 1'b0, 1'b0);
        chk("repeat_count", 32'(count), 32'h5);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b0);
        chk("release_count", 32'(count), 32'h5);
        drain();

        // Overfill with distinct presses
        for (int i = 0; i <= DEPTH; i++) begin
            step(8'h31 + 8'(i), 1'b0, 1'b0);
            step(8'h00, 1'b0, 1'b0);
        end
        chk("ovf_full",  32'(full),     32'h1);
        chk("ovf_count", 32'(count),    32'(DEPTH));
        chk("ovf_flag",  32'(overflow), 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("ovf_order", 32'(dout), 32'h31 + 32'(i));
            step(8'h00, 1'b1, 1'b0);
        end
        step(8'h00, 1'b0, 1'b1);

        // Full FIFO, press together with pop
        for (int i = 0; i < DEPTH; i++) begin
            step(8'h31 + 8'(i), 1'b0, 1'b0);
            step(8'h00, 1'b0, 1'b0);
        end
        step(8'h50, 1'b1, 1'b0);
        chk("pp_count", 32'(count),    32'(DEPTH));
        chk("pp_ovf",   32'(overflow), 32'h0);
        for (int i = 0; i < DEPTH - 1; i++) step(8'h00, 1'b1, 1'b0);
        chk("pp_tail", 32'(dout), 32'h50);
        drain();

        // Key change without release restarts the delay
        step(8'h41, 1'b0, 1'b0);
        step(8'h42, 1'b0, 1'b0);
        chk("chg_count", 32'(count), 32'h2);
        for (int i = 0; i < 3; i++) step(8'h42, 1'b0, 1'b0);
        chk("chg_nodelay", 32'(count), 32'h2);
        step(8'h42, 1'b0, 1'b0);
        chk("chg_repeat", 32'(count), 32'h3);
        step(8'h00, 1'b0, 1'b0);
        drain();

        // Overflowed, 3 left, then clear with a same-cycle press
        for (int i = 0; i <= DEPTH; i++) begin
            step(8'h20 + 8'(i), 1'b0, 1'b0);
            step(8'h00, 1'b0, 1'b0);
        end
        for (int i = 0; i < DEPTH - 3; i++) step(8'h00, 1'b1, 1'b0);
        chk("pre_clr_count", 32'(count),    32'h3);
        chk("pre_clr_ovf",   32'(overflow), 32'h1);
        step(8'h70, 1'b0, 1'b1);
        chk("clr_empty", 32'(empty),    32'h1);
        chk("clr_count", 32'(count),    32'h0);
        chk("clr_ovf",   32'(overflow), 32'h0);
        step(8'h00, 1'b0, 1'b0);

        // Asynchronous reset with entries queued
        step(8'h55, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        model_reset();
        chk("arst_empty", 32'(empty),    32'h1);
        chk("arst_count", 32'(count),    32'h0);
        chk("arst_dout",  32'(dout),     32'h0);
        chk("arst_ovf",   32'(overflow), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Random traffic
        cur  = 8'h00;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 3))
                    0: cur = 8'h00;
                    1: cur = 8'h41;
                    2: cur = 8'h42;
                    default: cur = 8'($urandom_range(1, 255));
                endcase
                hold = $urandom_range(1, 14);
            end
            hold--;
            step(cur, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kbd_fifo.md
Name: kbd_fifo

Overview:
Key-event buffer between the PS/2 keyboard decoder and the CPU's KBD_ASCII memory-mapped read port. It converts the decoder's level-style ASCII output (non-zero while a key is held) into discrete key events and adds typematic auto-repeat. Events are queued in a small FIFO, and the CPU pops them one at a time, so keystrokes are no longer lost between polls.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
REPEAT_DELAY, 500000, clock cycles from press to first auto-repeat; 0 disables auto-repeat
REPEAT_PERIOD, 50000, clock cycles between subsequent auto-repeats; minimum 1

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
key_ascii  input  8  decoder output; 0 = no key held, non-zero = held key code; synchronous to clock (CDC is the integrator's job)
rd_en  input  1  pop strobe, one cycle per pop; driven by the CPU read of KBD_ASCII
clear  input  1  synchronous flush strobe
dout  output  8  head entry (first-word-fall-through); 8'h00 when empty
empty  output  1  FIFO holds no entries
full  output  1  FIFO holds DEPTH entries
count  output  $clog2(DEPTH)+1  number of entries held
overflow  output  1  sticky flag: a push was dropped

Behaviour:
- Reset (async, active-high): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, overflow=0, dout=0, prev_key=0, repeat FSM=IDLE, repeat counter=0.
- Storage: DEPTH x 8 array with pointers one bit wider than the index. empty = (wr_ptr==rd_ptr); full = (index bits equal && MSBs differ). count = wr_ptr-rd_ptr, modulo 2*DEPTH. Pointers wrap naturally.
- dout is combinational from mem[rd_ptr] and is forced to 0 when empty. A pushed entry appears on dout after the push edge, i.e. one cycle after key_ascii changes.
- prev_key is a register that samples key_ascii every cycle.
- A press event occurs when key_ascii!=0 && key_ascii!=prev_key. It requests a push of key_ascii on that same edge.
- Repeat FSM:
  - IDLE: on a press event go to DELAY and set cnt=1.
  - DELAY: key_ascii==0 -> IDLE. A new press event -> restart DELAY with cnt=1. Otherwise cnt++. When cnt==REPEAT_DELAY, request a push of the current key, set cnt=1, go to REPEAT.
  - REPEAT: release -> IDLE; new press -> DELAY, cnt=1. Otherwise cnt++. When cnt==REPEAT_PERIOD, request a push and set cnt=1.
  - REPEAT_DELAY==0: the FSM stays in IDLE and only press events push.
  - Counter width: $clog2(max(REPEAT_DELAY,REPEAT_PERIOD))+1.
- At most one push request per cycle. Press and repeat requests are mutually exclusive by construction.
- Pop: rd_en && !empty -> rd_ptr++. rd_en while empty is ignored, with no side effects.
- Simultaneous push and pop:
  - Not empty: both occur, count unchanged.
  - Full: both occur, no overflow.
  - Empty: the push lands and the pop is ignored.
- Push request while full with no pop: the data is dropped and overflow is set to 1. overflow clears only on reset or clear.
- clear: on the next edge wr_ptr=rd_ptr=0 and overflow=0.
  - clear wins over a same-cycle push or pop; that push is dropped without setting overflow.
  - The repeat FSM and prev_key are unaffected, so a held key keeps repeating after a clear.
- key_ascii changing directly from one non-zero code to another counts as a new press: the new code is pushed and the delay restarts.
- Reset asserted mid-operation returns all state to the reset values immediately, regardless of clock.

Test Plan:
- Reset, then key_ascii=8'h41 for 1 cycle, then 0 -> after the edge, empty=0, count=1, dout=8'h41. Pulse rd_en -> empty=1, dout=8'h00.
- REPEAT_DELAY=4, REPEAT_PERIOD=2; hold 8'h61 for 12 cycles -> pushes at the press edge and at +4, +6, +8, +10; count=5. Release -> no further pushes.
- DEPTH=4; press 8'h31, 8'h32, 8'h33, 8'h34, 8'h35 with 0 between each -> full=1, count=4, overflow=1; pops return 31, 32, 33, 34 in order.
- Full FIFO, a press event together with rd_en in the same cycle -> count stays 4, overflow stays 0, the new code ends up at the tail.
- key_ascii steps 8'h41 -> 8'h42 with no release -> two entries (41, 42); the repeat delay restarts from the 42 edge.
- 3 entries queued with overflow=1; clear together with a press event -> empty=1, count=0, overflow=0, the pressed code is not stored. Reset pulsed while the FIFO is non-empty -> all outputs return to reset values asynchronously.
